// File: rtl/mpram_req_sched.sv
// Two-client request scheduler in front of a dual-port RAM: client a drives RAM port a,
// client b drives RAM port b, with credit-limited reads and per-port response FIFOs.

module mpram_rsp_port #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int AW    = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_accept,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] ram_data,
    input  logic             rsp_ready,
    output logic             credit,
    output logic [AW-1:0]    ram_addr,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             inflight;
    logic [AW-1:0]    addr_q;
    logic             push;
    logic             pop;

    assign push      = inflight;
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_valid = (count != '0);
    assign rsp_data  = mem[rd_ptr];
    assign ram_addr  = rd_accept ? req_addr : addr_q;

    // The read still inside the RAM register holds a slot, so every accepted read has room.
    assign credit = ({1'b0, count} + {{CW{1'b0}}, inflight}) < LIMIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
            addr_q   <= '0;
        end else begin
            inflight <= rd_accept;
            if (rd_accept) addr_q <= req_addr;
            if (push) begin
                mem[wr_ptr] <= ram_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end
endmodule

module mpram_req_sched #(
    parameter int  P_MEM_DEPTH    = 2048,
    parameter int  P_MEM_WIDTH    = 32,
    parameter int  P_RSP_DEPTH    = 4,
    localparam int LP_INDEX_WIDTH = $clog2(P_MEM_DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      a_req_valid_i,
    output logic                      a_req_ready_o,
    input  logic                      a_req_we_i,
    input  logic [LP_INDEX_WIDTH-1:0] a_req_addr_i,
    input  logic [P_MEM_WIDTH-1:0]    a_req_wdata_i,
    output logic                      a_rsp_valid_o,
    input  logic                      a_rsp_ready_i,
    output logic [P_MEM_WIDTH-1:0]    a_rsp_data_o,
    input  logic                      b_req_valid_i,
    output logic                      b_req_ready_o,
    input  logic                      b_req_we_i,
    input  logic [LP_INDEX_WIDTH-1:0] b_req_addr_i,
    input  logic [P_MEM_WIDTH-1:0]    b_req_wdata_i,
    output logic                      b_rsp_valid_o,
    input  logic                      b_rsp_ready_i,
    output logic [P_MEM_WIDTH-1:0]    b_rsp_data_o,
    output logic [LP_INDEX_WIDTH-1:0] rda_addr_o,
    input  logic [P_MEM_WIDTH-1:0]    rda_data_i,
    output logic [LP_INDEX_WIDTH-1:0] wra_addr_o,
    output logic [P_MEM_WIDTH-1:0]    wra_data_o,
    output logic                      wra_valid_o,
    output logic [LP_INDEX_WIDTH-1:0] rdb_addr_o,
    input  logic [P_MEM_WIDTH-1:0]    rdb_data_i,
    output logic [LP_INDEX_WIDTH-1:0] wrb_addr_o,
    output logic [P_MEM_WIDTH-1:0]    wrb_data_o,
    output logic                      wrb_valid_o
);
    logic conflict;
    logic a_credit;
    logic b_credit;
    logic a_rd_accept;
    logic b_rd_accept;

    // Same-address writes on both ports: a wins and b is stalled for the cycle.
    assign conflict = a_req_valid_i & a_req_we_i & b_req_valid_i & b_req_we_i &
                      (a_req_addr_i == b_req_addr_i);

    assign a_req_ready_o = rst_ni & (a_req_we_i | a_credit);
    assign b_req_ready_o = rst_ni & (b_req_we_i ? ~conflict : b_credit);

    assign a_rd_accept = a_req_valid_i & ~a_req_we_i & a_req_ready_o;
    assign b_rd_accept = b_req_valid_i & ~b_req_we_i & b_req_ready_o;

    assign wra_valid_o = a_req_valid_i & a_req_we_i & a_req_ready_o;
    assign wra_addr_o  = a_req_addr_i;
    assign wra_data_o  = a_req_wdata_i;
    assign wrb_valid_o = b_req_valid_i & b_req_we_i & b_req_ready_o;
    assign wrb_addr_o  = b_req_addr_i;
    assign wrb_data_o  = b_req_wdata_i;

    mpram_rsp_port #(
        .DEPTH (P_RSP_DEPTH),
        .WIDTH (P_MEM_WIDTH),
        .AW    (LP_INDEX_WIDTH)
    ) u_port_a (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .rd_accept (a_rd_accept),
        .req_addr  (a_req_addr_i),
        .ram_data  (rda_data_i),
        .rsp_ready (a_rsp_ready_i),
        .credit    (a_credit),
        .ram_addr  (rda_addr_o),
        .rsp_valid (a_rsp_valid_o),
        .rsp_data  (a_rsp_data_o)
    );

    mpram_rsp_port #(
        .DEPTH (P_RSP_DEPTH),
        .WIDTH (P_MEM_WIDTH),
        .AW    (LP_INDEX_WIDTH)
    ) u_port_b (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .rd_accept (b_rd_accept),
        .req_addr  (b_req_addr_i),
        .ram_data  (rdb_data_i),
        .rsp_ready (b_rsp_ready_i),
        .credit    (b_credit),
        .ram_addr  (rdb_addr_o),
        .rsp_valid (b_rsp_valid_o),
        .rsp_data  (b_rsp_data_o)
    );
endmodule
